// File: rtl/arm_dp_sequencer_pkg.sv
// arm_seq_pkg: shared encodings for the data-processing sequencer.
//   - FSM state codes (plain 3-bit constants)
//   - ARM condition-code values
//   - data-processing opcodes and the test/compare group mask (10xx)
//   - shifter type and mode encodings
package arm_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_DECODE   = 3'd1;
    localparam state_t ST_READ_RS  = 3'd2;
    localparam state_t ST_READ_OPS = 3'd3;
    localparam state_t ST_SHIFT    = 3'd4;
    localparam state_t ST_EXEC     = 3'd5;
    localparam state_t ST_WRITE    = 3'd6;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_RSB = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_TEQ = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_CMN = 4'b1011;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_BIC = 4'b1110;
    localparam logic [3:0] OP_MVN = 4'b1111;

    // TST/TEQ/CMP/CMN: opcode & mask == value
    localparam logic [3:0] OP_TEST_MASK = 4'b1100;
    localparam logic [3:0] OP_TEST_VAL  = 4'b1000;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    // shift_mode = {is_imm_rotate, type}
    localparam logic [2:0] SMODE_ROR_IMM = {1'b1, SH_ROR};

    function automatic logic is_test_op(input logic [3:0] op);
        return (op & OP_TEST_MASK) == OP_TEST_VAL;
    endfunction

    function automatic logic is_move_op(input logic [3:0] op);
        return (op == OP_MOV) || (op == OP_MVN);
    endfunction

endpackage

// File: rtl/arm_cond_check.sv
// arm_cond_check: combinational ARM condition evaluation.
//   cond : instruction condition field [31:28]
//   nzcv : current CPSR flags {N,Z,C,V}
//   pass : 1 when the instruction should execute
module arm_cond_check
    import arm_seq_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;
    assign {n, z, c, v} = nzcv;

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/arm_dp_sequencer.sv
// arm_dp_sequencer: multi-cycle sequencer for ARM data-processing
// instructions. Accepts one instruction per handshake, checks its
// condition, then walks the register bank, shifter and ALU through
// read, shift, execute and write-back.
//   instr_valid/instr/instr_ready : instruction handshake
//   flags                         : current CPSR NZCV
//   rd_addr*/rd_data*             : register bank read ports
//   shift_*                       : barrel shifter drive / result
//   alu_*                         : ALU operands, opcode, enable, result
//   wr_*                          : register write-back
//   cpsr_w/cpsr_nzcv              : flag write-back
//   retired/undef                 : completion pulses
//
// state       | meaning
// ------------+---------------------------------------------------
// IDLE        | ready for a new instruction
// DECODE      | group / condition check, pick read path
// READ_RS     | read Rs for a register-specified shift amount
// READ_OPS    | read Rn/Rm, build shifter inputs
// SHIFT       | capture shifter output as ALU operand B
// EXEC        | hold alu_active for ALU_LAT cycles
// WRITE       | register and/or flag write-back, retire
module arm_dp_sequencer
    import arm_seq_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 4,
    parameter int ALU_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    output logic              instr_ready,
    input  logic [3:0]        flags,
    output logic [REG_AW-1:0] rd_addr1,
    output logic [REG_AW-1:0] rd_addr2,
    input  logic [DATA_W-1:0] rd_data1,
    input  logic [DATA_W-1:0] rd_data2,
    output logic [DATA_W-1:0] shift_value,
    output logic [2:0]        shift_mode,
    output logic [4:0]        shift_count,
    input  logic [DATA_W-1:0] shift_result,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    output logic              alu_active,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_nzcv,
    output logic              wr_en,
    output logic [REG_AW-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpsr_w,
    output logic [3:0]        cpsr_nzcv,
    output logic              retired,
    output logic              undef
);

    localparam int CNT_W = $clog2(ALU_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LAT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    state_t            state;
    logic [31:0]       ir;
    logic [7:0]        shamt;
    logic [DATA_W-1:0] rn_q;
    logic [DATA_W-1:0] res_q;
    logic [3:0]        nzcv_q;
    logic [CNT_W-1:0]  exec_cnt;
    logic              ready_q;
    logic              cond_pass;

    logic [REG_AW-1:0] rn, rd, rs, rm;
    assign rn = REG_AW'(ir[19:16]);
    assign rd = REG_AW'(ir[15:12]);
    assign rs = REG_AW'(ir[11:8]);
    assign rm = REG_AW'(ir[3:0]);

    // ready only comes up on the first clock after reset release
    assign instr_ready = ready_q && (state == ST_IDLE);

    arm_cond_check u_cond (
        .cond (ir[31:28]),
        .nzcv (flags),
        .pass (cond_pass)
    );

    logic              amt_big;
    logic [DATA_W-1:0] sh_val_n;
    logic [2:0]        sh_mode_n;
    logic [4:0]        sh_cnt_n;

    assign amt_big = (32'(shamt) >= 32'(DATA_W));

    always_comb begin
        sh_val_n  = rd_data2;
        sh_mode_n = {1'b0, ir[6:5]};
        sh_cnt_n  = ir[11:7];
        if (ir[25]) begin
            sh_val_n  = DATA_W'(ir[7:0]);
            sh_mode_n = SMODE_ROR_IMM;
            sh_cnt_n  = {ir[11:8], 1'b0};
        end else if (ir[4]) begin
            sh_cnt_n = shamt[4:0];
            // oversized register amounts saturate; ROR just wraps
            if (amt_big) begin
                case (ir[6:5])
                    SH_LSL, SH_LSR: begin
                        sh_val_n = '0;
                        sh_cnt_n = '0;
                    end
                    SH_ASR:  sh_cnt_n = 5'(DATA_W - 1);
                    default: sh_cnt_n = shamt[4:0];
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            ir          <= '0;
            shamt       <= '0;
            rn_q        <= '0;
            res_q       <= '0;
            nzcv_q      <= '0;
            exec_cnt    <= '0;
            ready_q     <= 1'b0;
            rd_addr1    <= '0;
            rd_addr2    <= '0;
            shift_value <= '0;
            shift_mode  <= '0;
            shift_count <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            alu_active  <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            cpsr_w      <= 1'b0;
            cpsr_nzcv   <= '0;
            retired     <= 1'b0;
            undef       <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            wr_en   <= 1'b0;
            cpsr_w  <= 1'b0;
            retired <= 1'b0;
            undef   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (instr_valid && instr_ready) begin
                        ir    <= instr;
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (ir[27:26] != 2'b00) begin
                        undef   <= 1'b1;
                        retired <= 1'b1;
                        state   <= ST_IDLE;
                    end else if (!cond_pass) begin
                        retired <= 1'b1;
                        state   <= ST_IDLE;
                    end else if (!ir[25] && ir[4]) begin
                        rd_addr1 <= rs;
                        state    <= ST_READ_RS;
                    end else begin
                        rd_addr1 <= rn;
                        rd_addr2 <= rm;
                        state    <= ST_READ_OPS;
                    end
                end
                ST_READ_RS: begin
                    shamt    <= rd_data1[7:0];
                    rd_addr1 <= rn;
                    rd_addr2 <= rm;
                    state    <= ST_READ_OPS;
                end
                ST_READ_OPS: begin
                    rn_q        <= rd_data1;
                    shift_value <= sh_val_n;
                    shift_mode  <= sh_mode_n;
                    shift_count <= sh_cnt_n;
                    state       <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    alu_b      <= shift_result;
                    alu_a      <= is_move_op(ir[24:21]) ? '0 : rn_q;
                    alu_op     <= ir[24:21];
                    alu_active <= 1'b1;
                    exec_cnt   <= CNT_LOAD;
                    state      <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (exec_cnt == CNT_LAST) begin
                        res_q      <= alu_result;
                        nzcv_q     <= alu_nzcv;
                        alu_active <= 1'b0;
                        state      <= ST_WRITE;
                    end else begin
                        exec_cnt <= exec_cnt - CNT_LAST;
                    end
                end
                ST_WRITE: begin
                    if (!is_test_op(ir[24:21])) begin
                        wr_en   <= 1'b1;
                        wr_addr <= rd;
                        wr_data <= res_q;
                    end
                    if (ir[20] || is_test_op(ir[24:21])) begin
                        cpsr_w    <= 1'b1;
                        cpsr_nzcv <= nzcv_q;
                    end
                    retired <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arm_dp_sequencer.sv
// Directed bench for arm_dp_sequencer: one instance with ALU_LAT=2 and
// one with ALU_LAT=5, sharing a register-bank, shifter and ALU model.
module tb_arm_dp_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] regs [16];
    logic [3:0]  flags;
    logic [31:0] instr;
    bit          sel5;

    // ---------------- instance A (ALU_LAT=2)
    logic        instr_valid, instr_ready;
    logic [3:0]  rd_addr1, rd_addr2;
    logic [31:0] rd_data1, rd_data2, shift_value, shift_result;
    logic [2:0]  shift_mode;
    logic [4:0]  shift_count;
    logic [31:0] alu_a, alu_b, alu_result, wr_data;
    logic [3:0]  alu_op, alu_nzcv, wr_addr, cpsr_nzcv;
    logic        alu_active, wr_en, cpsr_w, retired, undef;

    // ---------------- instance B (ALU_LAT=5)
    logic        instr_valid_5, instr_ready_5;
    logic [3:0]  rd_addr1_5, rd_addr2_5;
    logic [31:0] rd_data1_5, rd_data2_5, shift_value_5, shift_result_5;
    logic [2:0]  shift_mode_5;
    logic [4:0]  shift_count_5;
    logic [31:0] alu_a_5, alu_b_5, alu_result_5, wr_data_5;
    logic [3:0]  alu_op_5, alu_nzcv_5, wr_addr_5, cpsr_nzcv_5;
    logic        alu_active_5, wr_en_5, cpsr_w_5, retired_5, undef_5;

    function automatic logic [31:0] shifter_f(input logic [31:0] v, input logic [2:0] m,
                                              input logic [4:0] c);
        if (m[2] || m[1:0] == 2'b11) return (v >> c) | (v << (6'd32 - {1'b0, c}));
        case (m[1:0])
            2'b00:   return v << c;
            2'b01:   return v >> c;
            default: return 32'($signed(v) >>> c);
        endcase
    endfunction

    function automatic logic [35:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [3:0] f);
        logic [32:0] s;
        logic [31:0] r;
        logic        c, v;
        c = f[1];
        v = f[0];
        r = '0;
        case (op)
            4'b0100, 4'b1011: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'b0010, 4'b1010: begin
                s = {1'b0, a} - {1'b0, b};
                r = s[31:0];
                c = ~s[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'b0000, 4'b1000: r = a & b;
            4'b0001, 4'b1001: r = a ^ b;
            4'b1100: r = a | b;
            4'b1101: r = b;
            4'b1110: r = a & ~b;
            4'b1111: r = ~b;
            default: r = '0;
        endcase
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    assign rd_data1       = regs[rd_addr1];
    assign rd_data2       = regs[rd_addr2];
    assign shift_result   = shifter_f(shift_value, shift_mode, shift_count);
    assign {alu_nzcv, alu_result} = alu_active ? alu_f(alu_op, alu_a, alu_b, flags) : 36'd0;

    assign rd_data1_5     = regs[rd_addr1_5];
    assign rd_data2_5     = regs[rd_addr2_5];
    assign shift_result_5 = shifter_f(shift_value_5, shift_mode_5, shift_count_5);
    assign {alu_nzcv_5, alu_result_5} = alu_active_5 ? alu_f(alu_op_5, alu_a_5, alu_b_5, flags) : 36'd0;

    arm_dp_sequencer #(.DATA_W(32), .REG_AW(4), .ALU_LAT(2)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .flags(flags),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1), .rd_data2(rd_data2),
        .shift_value(shift_value), .shift_mode(shift_mode), .shift_count(shift_count),
        .shift_result(shift_result), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_active(alu_active), .alu_result(alu_result), .alu_nzcv(alu_nzcv),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .cpsr_w(cpsr_w),
        .cpsr_nzcv(cpsr_nzcv), .retired(retired), .undef(undef)
    );

    arm_dp_sequencer #(.DATA_W(32), .REG_AW(4), .ALU_LAT(5)) dut5 (
        .clk(clk), .rst(rst), .instr_valid(instr_valid_5), .instr(instr),
        .instr_ready(instr_ready_5), .flags(flags),
        .rd_addr1(rd_addr1_5), .rd_addr2(rd_addr2_5), .rd_data1(rd_data1_5), .rd_data2(rd_data2_5),
        .shift_value(shift_value_5), .shift_mode(shift_mode_5), .shift_count(shift_count_5),
        .shift_result(shift_result_5), .alu_a(alu_a_5), .alu_b(alu_b_5), .alu_op(alu_op_5),
        .alu_active(alu_active_5), .alu_result(alu_result_5), .alu_nzcv(alu_nzcv_5),
        .wr_en(wr_en_5), .wr_addr(wr_addr_5), .wr_data(wr_data_5), .cpsr_w(cpsr_w_5),
        .cpsr_nzcv(cpsr_nzcv_5), .retired(retired_5), .undef(undef_5)
    );

    // view of whichever instance the current scenario drives
    logic        s_wr_en, s_cpsr_w, s_retired, s_undef, s_alu_active;
    logic [3:0]  s_wr_addr, s_cpsr_nzcv, s_rd_addr1, s_rd_addr2;
    logic [31:0] s_wr_data;
    assign s_wr_en      = sel5 ? wr_en_5      : wr_en;
    assign s_cpsr_w     = sel5 ? cpsr_w_5     : cpsr_w;
    assign s_retired    = sel5 ? retired_5    : retired;
    assign s_undef      = sel5 ? undef_5      : undef;
    assign s_alu_active = sel5 ? alu_active_5 : alu_active;
    assign s_wr_addr    = sel5 ? wr_addr_5    : wr_addr;
    assign s_wr_data    = sel5 ? wr_data_5    : wr_data;
    assign s_cpsr_nzcv  = sel5 ? cpsr_nzcv_5  : cpsr_nzcv;
    assign s_rd_addr1   = sel5 ? rd_addr1_5   : rd_addr1;
    assign s_rd_addr2   = sel5 ? rd_addr2_5   : rd_addr2;

    int          lat, n_wr, n_cpsr, n_undef, n_act;
    logic        tail;
    logic [3:0]  l_wr_addr, l_nzcv, a1_c1, a2_c1, a1_c2;
    logic [31:0] l_wr_data;

    // Handshake one instruction and record what happens until retired.
    task automatic issue(input bit use5, input logic [31:0] word);
        sel5 = use5;
        @(negedge clk);
        instr = word;
        if (use5) instr_valid_5 = 1'b1; else instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid   = 1'b0;
        instr_valid_5 = 1'b0;
        lat = -1; n_wr = 0; n_cpsr = 0; n_undef = 0; n_act = 0;
        l_wr_addr = '0; l_wr_data = '0; l_nzcv = '0;
        for (int cyc = 1; cyc <= 40 && lat < 0; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) begin a1_c1 = s_rd_addr1; a2_c1 = s_rd_addr2; end
            if (cyc == 2) a1_c2 = s_rd_addr1;
            if (s_alu_active) n_act++;
            if (s_undef) n_undef++;
            if (s_wr_en) begin n_wr++; l_wr_addr = s_wr_addr; l_wr_data = s_wr_data; end
            if (s_cpsr_w) begin n_cpsr++; l_nzcv = s_cpsr_nzcv; end
            if (s_retired) lat = cyc;
        end
        @(posedge clk); #1;
        tail = s_wr_en | s_cpsr_w | s_retired | s_undef;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", instr_ready); end
        checks++; if ({wr_en, cpsr_w, retired, undef, alu_active} !== 5'b0) begin errors++; $display("FAIL reset_pulses: got %b want 00000", {wr_en, cpsr_w, retired, undef, alu_active}); end
        checks++; if ({shift_value, alu_a, alu_b, wr_data} !== 128'd0) begin errors++; $display("FAIL reset_data: got %h want 0", {shift_value, alu_a, alu_b, wr_data}); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL ready_before_clock: got %b want 0", instr_ready); end
        @(posedge clk); #1;
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL ready_after_clock: got %b want 1", instr_ready); end
    endtask

    task automatic test_imm_add();
        issue(1'b0, 32'hE290_000F);   // ADDS R0,R0,#0x0f
        checks++; if (lat !== 6) begin errors++; $display("FAIL imm_add_latency: got %0d want 6", lat); end
        checks++; if (n_wr !== 1 || l_wr_addr !== 4'd0 || l_wr_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL imm_add_write: got n=%0d R%0d=%h want 1 R0=ffffffff", n_wr, l_wr_addr, l_wr_data); end
        checks++; if (n_cpsr !== 1 || l_nzcv !== 4'b1000) begin errors++; $display("FAIL imm_add_flags: got n=%0d %b want 1 1000", n_cpsr, l_nzcv); end
        checks++; if (n_act !== 2) begin errors++; $display("FAIL imm_add_alu_cycles: got %0d want 2", n_act); end
        checks++; if (tail !== 1'b0) begin errors++; $display("FAIL imm_add_pulse_width: got %b want 0", tail); end
    endtask

    task automatic test_reg_imm_shift();
        issue(1'b0, 32'hE090_0001);   // ADDS R0,R0,R1 LSL #0
        checks++; if (a1_c1 !== 4'd0 || a2_c1 !== 4'd1) begin errors++; $display("FAIL regimm_addrs: got %0d/%0d want 0/1", a1_c1, a2_c1); end
        checks++; if (lat !== 6) begin errors++; $display("FAIL regimm_latency: got %0d want 6", lat); end
        checks++; if (l_wr_data !== 32'hFFFF_FFFF || l_nzcv !== 4'b1000) begin errors++; $display("FAIL regimm_result: got %h %b want ffffffff 1000", l_wr_data, l_nzcv); end
    endtask

    task automatic test_reg_shift();
        issue(1'b0, 32'hE000_0211);   // AND R0,R0,R1 LSL R2, R2=0x21
        checks++; if (a1_c1 !== 4'd2 || a1_c2 !== 4'd0) begin errors++; $display("FAIL regshift_addrs: got %0d then %0d want 2 then 0", a1_c1, a1_c2); end
        checks++; if (shift_value !== 32'd0 || shift_count !== 5'd0) begin errors++; $display("FAIL regshift_saturate: got %h/%0d want 0/0", shift_value, shift_count); end
        checks++; if (lat !== 7) begin errors++; $display("FAIL regshift_latency: got %0d want 7", lat); end
        checks++; if (n_wr !== 1 || l_wr_data !== 32'd0 || n_cpsr !== 0) begin errors++; $display("FAIL regshift_write: got n=%0d %h cpsr=%0d want 1 0 0", n_wr, l_wr_data, n_cpsr); end
    endtask

    task automatic test_cond();
        flags = 4'b0000;
        issue(1'b0, 32'h0351_000F);   // CMPEQ R1,#0xf, Z=0
        checks++; if (lat !== 1 || n_wr !== 0 || n_cpsr !== 0) begin errors++; $display("FAIL cond_false: got lat=%0d wr=%0d cpsr=%0d want 1 0 0", lat, n_wr, n_cpsr); end
        checks++; if (tail !== 1'b0) begin errors++; $display("FAIL cond_false_pulse: got %b want 0", tail); end
        flags = 4'b0100;
        issue(1'b0, 32'h0351_000F);   // CMPEQ R1,#0xf, Z=1
        checks++; if (lat !== 6 || n_wr !== 0) begin errors++; $display("FAIL cond_true: got lat=%0d wr=%0d want 6 0", lat, n_wr); end
        checks++; if (n_cpsr !== 1 || l_nzcv !== 4'b0110) begin errors++; $display("FAIL cmp_flags: got n=%0d %b want 1 0110", n_cpsr, l_nzcv); end
        flags = 4'b0000;
        issue(1'b0, 32'hF290_000F);   // condition 1111 never executes
        checks++; if (lat !== 1 || n_wr !== 0 || n_undef !== 0) begin errors++; $display("FAIL cond_nv: got lat=%0d wr=%0d undef=%0d want 1 0 0", lat, n_wr, n_undef); end
    endtask

    task automatic test_alu_lat5();
        issue(1'b1, 32'hE3A0_34FF);   // MOV R3,#0xff ror 8
        checks++; if (shift_count_5 !== 5'd8 || shift_mode_5 !== 3'b111) begin errors++; $display("FAIL rot_imm_shift: got %0d/%b want 8/111", shift_count_5, shift_mode_5); end
        checks++; if (n_act !== 5) begin errors++; $display("FAIL lat5_alu_cycles: got %0d want 5", n_act); end
        checks++; if (lat !== 9) begin errors++; $display("FAIL lat5_latency: got %0d want 9", lat); end
        checks++; if (n_wr !== 1 || l_wr_addr !== 4'd3 || l_wr_data !== 32'hFF00_0000 || n_cpsr !== 0) begin errors++; $display("FAIL lat5_write: got R%0d=%h cpsr=%0d want R3=ff000000 0", l_wr_addr, l_wr_data, n_cpsr); end
        sel5 = 1'b0;
    endtask

    task automatic test_reset_exec();
        int bad;
        sel5 = 1'b0;
        @(negedge clk);
        instr = 32'hE290_000F;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        for (int i = 0; i < 10 && !alu_active; i++) begin
            @(posedge clk); #1;
        end
        checks++; if (alu_active !== 1'b1) begin errors++; $display("FAIL reach_exec: got %b want 1", alu_active); end
        #1 rst = 1'b1;
        #1;
        checks++; if ({alu_active, instr_ready, wr_en, retired, cpsr_w} !== 5'b0 || alu_a !== 32'd0 || shift_value !== 32'd0) begin errors++; $display("FAIL async_reset_outputs: got %b %h %h want 0", {alu_active, instr_ready, wr_en, retired, cpsr_w}, alu_a, shift_value); end
        bad = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (wr_en || retired) bad++;
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (wr_en || retired) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL dropped_instr: got %0d pulses want 0", bad); end
        issue(1'b0, 32'hE290_000F);
        checks++; if (lat !== 6 || l_wr_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL post_reset_instr: got lat=%0d %h want 6 ffffffff", lat, l_wr_data); end
        issue(1'b0, 32'hE400_0000);   // group 01
        checks++; if (lat !== 1 || n_undef !== 1 || n_wr !== 0 || n_cpsr !== 0) begin errors++; $display("FAIL undef: got lat=%0d undef=%0d wr=%0d cpsr=%0d want 1 1 0 0", lat, n_undef, n_wr, n_cpsr); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 32'd0;
        regs[0] = 32'hFFFF_FFF0;
        regs[1] = 32'h0000_000F;
        regs[2] = 32'h0000_0021;
        flags = 4'b0000;
        instr = '0;
        instr_valid = 1'b0;
        instr_valid_5 = 1'b0;
        sel5 = 1'b0;
        test_reset();
        test_imm_add();
        test_reg_imm_shift();
        test_reg_shift();
        test_cond();
        test_alu_lat5();
        test_reset_exec();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
